// File: rtl/dtree_channel_arbiter.sv
// dtree_channel_arbiter
//
// Shares one dtree classifier between CHANNELS spike-detect channels. Channels are
// granted round-robin. Each granted feature vector is latched and then sent into the
// dtree sample stream one feature per beat, feature 0 first. The arbiter waits for
// the classification and returns level/path tagged with the channel index. It also
// owns the dtree node-memory write port. Configuration writes are accepted only in
// IDLE, so they never overlap an in-flight classification.
//
// Optional feature: define DTREE_ARB_TIMEOUT_EN to add a WAIT watchdog. After
// TIMEOUT_CYCLES cycles without dt_out_valid, the arbiter returns a result with
// res_err=1 and level/path=0. When the macro is undefined, res_err is tied to 0.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_ready per-channel request; req_ready is a one-cycle one-hot accept
//   req_features        flat vectors, channel c feature f at (c*FEATURES+f)*IN_WIDTH
//   cfg_wr/addr/data    node write request; cfg_ready pulses when it is accepted
//   dt_ready/valid/sample          sample stream to the dtree
//   dt_wr_node/node_addr/node_data node-memory write port to the dtree
//   dt_level/path/out_valid        classification result from the dtree
//   res_valid/ready/channel/level/path/err  tagged result to the consumer

module dtree_channel_arbiter #(
    parameter int unsigned FEATURES        = 3,
    parameter int unsigned IN_WIDTH        = 10,
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned NODE_ADDR_WIDTH = 5,
    parameter int unsigned NODE_SIZE       = 26,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [CHANNELS-1:0]                    req_valid,
    output logic [CHANNELS-1:0]                    req_ready,
    input  logic [CHANNELS*FEATURES*IN_WIDTH-1:0]  req_features,
    input  logic                                   cfg_wr,
    input  logic [NODE_ADDR_WIDTH-1:0]             cfg_addr,
    input  logic [NODE_SIZE-1:0]                   cfg_data,
    output logic                                   cfg_ready,
    input  logic                                   dt_ready,
    output logic                                   dt_valid,
    output logic [IN_WIDTH-1:0]                    dt_sample,
    output logic                                   dt_wr_node,
    output logic [NODE_ADDR_WIDTH-1:0]             dt_node_addr,
    output logic [NODE_SIZE-1:0]                   dt_node_data,
    input  logic [1:0]                             dt_level,
    input  logic [1:0]                             dt_path,
    input  logic                                   dt_out_valid,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [$clog2(CHANNELS)-1:0]            res_channel,
    output logic [1:0]                             res_level,
    output logic [1:0]                             res_path,
    output logic                                   res_err
);

    localparam int unsigned CH_W  = $clog2(CHANNELS);
    localparam int unsigned CNT_W = (FEATURES > 1) ? $clog2(FEATURES) : 1;
    localparam int unsigned VEC_W = FEATURES * IN_WIDTH;

    typedef enum logic [2:0] {StIdle, StCfg, StSend, StWait, StResp} state_e;

    state_e              state_q;
    logic [CH_W-1:0]     ptr_q;
    logic [CH_W-1:0]     gnt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [VEC_W-1:0]    vec_q;

    logic                grant_found;
    logic [CH_W-1:0]     grant_idx;
    logic [CH_W:0]       scan_idx;
    logic                take_cfg;
    logic                take_req;

    // Round-robin search: the first requester at or above ptr_q, wrapping to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            scan_idx = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (scan_idx >= (CH_W+1)'(CHANNELS)) begin
                scan_idx = scan_idx - (CH_W+1)'(CHANNELS);
            end
            if (!grant_found && req_valid[scan_idx[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[CH_W-1:0];
            end
        end
    end

    // A configuration write wins over channel requests in IDLE.
    assign take_cfg = (state_q == StIdle) && cfg_wr;
    assign take_req = (state_q == StIdle) && !cfg_wr && grant_found;

    // The handshake strobes are gated by reset, so every output is 0 while reset is held.
    always_comb begin
        req_ready = '0;
        if (take_req && !reset) begin
            req_ready = CHANNELS'(1) << grant_idx;
        end
        cfg_ready = take_cfg && !reset;
        dt_valid  = (state_q == StSend) && dt_ready && !reset;
        dt_sample = '0;
        if (state_q == StSend) begin
            dt_sample = vec_q[cnt_q*IN_WIDTH +: IN_WIDTH];
        end
    end

`ifdef DTREE_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
`else
    assign res_err = 1'b0;
    // The limit has no effect when the watchdog is compiled out.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            gnt_q        <= '0;
            cnt_q        <= '0;
            vec_q        <= '0;
            dt_wr_node   <= 1'b0;
            dt_node_addr <= '0;
            dt_node_data <= '0;
            res_valid    <= 1'b0;
            res_channel  <= '0;
            res_level    <= '0;
            res_path     <= '0;
`ifdef DTREE_ARB_TIMEOUT_EN
            res_err      <= 1'b0;
            tmo_q        <= '0;
`endif
        end else begin
            dt_wr_node <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (take_cfg) begin
                        // The write strobe lines up with the single CFG cycle.
                        dt_wr_node   <= 1'b1;
                        dt_node_addr <= cfg_addr;
                        dt_node_data <= cfg_data;
                        state_q      <= StCfg;
                    end else if (take_req) begin
                        vec_q   <= req_features[grant_idx*VEC_W +: VEC_W];
                        gnt_q   <= grant_idx;
                        ptr_q   <= (grant_idx == CH_W'(CHANNELS - 1)) ? '0
                                                                      : grant_idx + 1'b1;
                        state_q <= StSend;
                    end
                end
                StCfg: begin
                    state_q <= StIdle;
                end
                StSend: begin
                    if (dt_ready) begin
                        if (cnt_q == CNT_W'(FEATURES - 1)) begin
                            cnt_q   <= '0;
                            state_q <= StWait;
`ifdef DTREE_ARB_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (dt_out_valid) begin
                        res_level   <= dt_level;
                        res_path    <= dt_path;
                        res_channel <= gnt_q;
                        res_valid   <= 1'b1;
`ifdef DTREE_ARB_TIMEOUT_EN
                        res_err     <= 1'b0;
`endif
                        state_q     <= StResp;
                    end
`ifdef DTREE_ARB_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        res_level   <= '0;
                        res_path    <= '0;
                        res_channel <= gnt_q;
                        res_valid   <= 1'b1;
                        res_err     <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                StResp: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtree_channel_arbiter.sv
module tb_dtree_channel_arbiter;

    localparam int unsigned FEATURES = 3;
    localparam int unsigned IN_WIDTH = 10;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned NAW      = 5;
    localparam int unsigned NSZ      = 26;
`ifdef DTREE_ARB_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic                                  clk;
    logic                                  reset;
    logic [CHANNELS-1:0]                   req_valid;
    logic [CHANNELS-1:0]                   req_ready;
    logic [CHANNELS*FEATURES*IN_WIDTH-1:0] req_features;
    logic                                  cfg_wr;
    logic [NAW-1:0]                        cfg_addr;
    logic [NSZ-1:0]                        cfg_data;
    logic                                  cfg_ready;
    logic                                  dt_ready;
    logic                                  dt_valid;
    logic [IN_WIDTH-1:0]                   dt_sample;
    logic                                  dt_wr_node;
    logic [NAW-1:0]                        dt_node_addr;
    logic [NSZ-1:0]                        dt_node_data;
    logic [1:0]                            dt_level;
    logic [1:0]                            dt_path;
    logic                                  dt_out_valid;
    logic                                  res_valid;
    logic                                  res_ready;
    logic [1:0]                            res_channel;
    logic [1:0]                            res_level;
    logic [1:0]                            res_path;
    logic                                  res_err;

    int checks = 0;
    int errors = 0;
    logic [IN_WIDTH-1:0] feat [CHANNELS][FEATURES];

    dtree_channel_arbiter #(
        .FEATURES       (FEATURES),
        .IN_WIDTH       (IN_WIDTH),
        .CHANNELS       (CHANNELS),
        .NODE_ADDR_WIDTH(NAW),
        .NODE_SIZE      (NSZ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_features(req_features),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .dt_ready    (dt_ready),
        .dt_valid    (dt_valid),
        .dt_sample   (dt_sample),
        .dt_wr_node  (dt_wr_node),
        .dt_node_addr(dt_node_addr),
        .dt_node_data(dt_node_data),
        .dt_level    (dt_level),
        .dt_path     (dt_path),
        .dt_out_valid(dt_out_valid),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_channel (res_channel),
        .res_level   (res_level),
        .res_path    (res_path),
        .res_err     (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_features();
        for (int c = 0; c < CHANNELS; c++) begin
            for (int f = 0; f < FEATURES; f++) begin
                req_features[(c*FEATURES+f)*IN_WIDTH +: IN_WIDTH] = feat[c][f];
            end
        end
    endtask

    // One full classification starting at an IDLE cycle; ends in RESP with res_ready=1.
    task automatic txn(input int g, input logic [1:0] lv, input logic [1:0] pt,
                       input logic [3:0] rv);
        @(negedge clk);
        res_ready = 1'b0;
        req_valid = rv;
        #1;
        chk("grant", req_ready, 32'(1) << g);
        for (int f = 0; f < FEATURES; f++) begin
            @(negedge clk);
            #1;
            chk("send_valid", dt_valid, 1);
            chk("send_sample", dt_sample, feat[g][f]);
            chk("ready_pulse", req_ready, 0);
        end
        @(negedge clk);
        dt_out_valid = 1'b1;
        dt_level     = lv;
        dt_path      = pt;
        #1;
        chk("wait_no_valid", dt_valid, 0);
        @(negedge clk);
        dt_out_valid = 1'b0;
        res_ready    = 1'b1;
        #1;
        chk("res_valid", res_valid, 1);
        chk("res_channel", res_channel, g);
        chk("res_level", res_level, lv);
        chk("res_path", res_path, pt);
        chk("res_err", res_err, 0);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_features = '0;
        cfg_wr       = 1'b0;
        cfg_addr     = '0;
        cfg_data     = '0;
        dt_ready     = 1'b1;
        dt_level     = '0;
        dt_path      = '0;
        dt_out_valid = 1'b0;
        res_ready    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int f = 0; f < FEATURES; f++) begin
                feat[c][f] = IN_WIDTH'((c + 1) * 100 + f * 7 + 1);
            end
        end
        feat[2][0] = 10'd100;
        feat[2][1] = 10'd200;
        feat[2][2] = 10'd300;
        pack_features();

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_dt_valid", dt_valid, 0);
        chk("rst_wr_node", dt_wr_node, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_err", res_err, 0);

        // Configuration write
        @(negedge clk);
        reset    = 1'b0;
        cfg_wr   = 1'b1;
        cfg_addr = 5'd3;
        cfg_data = 26'h2A5F00;
        #1;
        chk("cfg_ready", cfg_ready, 1);
        chk("cfg_wr_early", dt_wr_node, 0);
        @(negedge clk);
        cfg_wr = 1'b0;
        #1;
        chk("cfg_ready_drop", cfg_ready, 0);
        chk("cfg_wr_node", dt_wr_node, 1);
        chk("cfg_addr", dt_node_addr, 3);
        chk("cfg_data", dt_node_data, 32'h2A5F00);
        chk("cfg_no_valid", dt_valid, 0);
        @(negedge clk);
        #1;
        chk("cfg_wr_pulse", dt_wr_node, 0);

        // Channel 2 only
        txn(2, 2'd2, 2'b01, 4'b0100);
        @(negedge clk);
        res_ready = 1'b0;
        req_valid = '0;
        #1;
        chk("res_done", res_valid, 0);

        // Reset clears the pointer, then all channels compete: 0,1,2,3,0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            txn(k % 4, 2'(k), 2'(3 - (k % 4)), 4'hF);
        end

        // dt_ready stall on channel 1 (pointer now 1)
        @(negedge clk);
        res_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("stall_grant", req_ready, 4'b0010);
        @(negedge clk);
        #1;
        chk("stall_b0", dt_sample, feat[1][0]);
        chk("stall_v0", dt_valid, 1);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            dt_ready = 1'b0;
            #1;
            chk("stall_low", dt_valid, 0);
            chk("stall_hold", dt_sample, feat[1][1]);
        end
        @(negedge clk);
        dt_ready = 1'b1;
        #1;
        chk("stall_b1", dt_sample, feat[1][1]);
        chk("stall_v1", dt_valid, 1);
        @(negedge clk);
        #1;
        chk("stall_b2", dt_sample, feat[1][2]);
        @(negedge clk);
        dt_out_valid = 1'b1;
        dt_level     = 2'd1;
        dt_path      = 2'd3;
        #1;
        chk("stall_wait", dt_valid, 0);
        @(negedge clk);
        dt_out_valid = 1'b0;
        res_ready    = 1'b1;
        #1;
        chk("stall_res_ch", res_channel, 1);
        chk("stall_res_lv", res_level, 1);
        chk("stall_res_pt", res_path, 3);

        // Back-pressure on the result with cfg_wr pending (grant goes to 2)
        @(negedge clk);
        res_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("bp_grant", req_ready, 4'b0100);
        for (int f = 0; f < FEATURES; f++) begin
            @(negedge clk);
        end
        @(negedge clk);
        dt_out_valid = 1'b1;
        dt_level     = 2'd3;
        dt_path      = 2'd2;
        @(negedge clk);
        dt_out_valid = 1'b0;
        cfg_wr       = 1'b1;
        cfg_addr     = 5'd7;
        cfg_data     = 26'h123;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("bp_valid", res_valid, 1);
            chk("bp_ch", res_channel, 2);
            chk("bp_lv", res_level, 3);
            chk("bp_pt", res_path, 2);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_cfg_ready", cfg_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_hs_cfg", cfg_ready, 0);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("bp_cfg_take", cfg_ready, 1);
        chk("bp_cfg_prio", req_ready, 0);
        chk("bp_res_clr", res_valid, 0);
        @(negedge clk);
        cfg_wr = 1'b0;
        #1;
        chk("bp_wr_node", dt_wr_node, 1);
        chk("bp_wr_addr", dt_node_addr, 7);

        // Reset during SEND (grant goes to 3)
        @(negedge clk);
        #1;
        chk("mid_grant", req_ready, 4'b1000);
        @(negedge clk);
        #1;
        chk("mid_send", dt_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", dt_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            #1;
            chk("mid_no_res", res_valid, 0);
            chk("mid_no_valid", dt_valid, 0);
        end
        txn(0, 2'd1, 2'd1, 4'hF);

`ifdef DTREE_ARB_TIMEOUT_EN
        // Watchdog on channel 1
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("tmo_grant", req_ready, 4'b0010);
        req_valid = '0;
        for (int f = 0; f < FEATURES; f++) begin
            @(negedge clk);
        end
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            #1;
            chk("tmo_wait", res_valid, 0);
        end
        @(negedge clk);
        #1;
        chk("tmo_valid", res_valid, 1);
        chk("tmo_err", res_err, 1);
        chk("tmo_lv", res_level, 0);
        chk("tmo_pt", res_path, 0);
        chk("tmo_ch", res_channel, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dtree_channel_arbiter.md
Name: dtree_channel_arbiter

Overview:
Shares one dtree classifier between CHANNELS spike-detect channels. Each channel presents a complete feature vector; the arbiter grants channels round-robin, serializes the vector into the dtree sample stream one feature per beat, waits for the classification, and returns level/path tagged with the channel index. It also owns the dtree node-memory write port and sequences configuration writes so they never collide with an in-flight classification.

Parameters:
FEATURES, 3, features per vector (beats per classification)
IN_WIDTH, 10, feature/sample width
CHANNELS, 4, number of requesting channels (>=2)
NODE_ADDR_WIDTH, 5, dtree node address width ($clog2(MAX_CLUSTERS*CHANNELS))
NODE_SIZE, 26, dtree node word width
TIMEOUT_CYCLES, 255, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  CHANNELS  per-channel vector valid
req_ready  out  CHANNELS  per-channel accept strobe, one-hot, one cycle
req_features  in  CHANNELS*FEATURES*IN_WIDTH  flat vectors; channel c, feature f at [(c*FEATURES+f)*IN_WIDTH +: IN_WIDTH]
cfg_wr  in  1  node write request
cfg_addr  in  NODE_ADDR_WIDTH  node address
cfg_data  in  NODE_SIZE  node word
cfg_ready  out  1  cfg write accepted this cycle
dt_ready  in  1  dtree ready
dt_valid  out  1  sample valid to dtree
dt_sample  out  IN_WIDTH  sample to dtree
dt_wr_node  out  1  node write strobe
dt_node_addr  out  NODE_ADDR_WIDTH  node address
dt_node_data  out  NODE_SIZE  node word
dt_level  in  2  dtree result level
dt_path  in  2  dtree result path
dt_out_valid  in  1  dtree result valid
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_channel  out  $clog2(CHANNELS)  channel of result
res_level  out  2  registered level
res_path  out  2  registered path
res_err  out  1  timeout flag (0 when feature compiled out)

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; feature counter 0.
- States: IDLE -> CFG | SEND; CFG -> IDLE; SEND -> WAIT; WAIT -> RESP; RESP -> IDLE.
- IDLE priority: cfg_wr beats any req_valid. cfg_wr=1 -> cfg_ready=1 same cycle; next cycle (CFG) dt_wr_node=1 for exactly one cycle with registered addr/data; back to IDLE. cfg_ready is 0 in every other state.
- Grant (IDLE, no cfg_wr, any req_valid): first set bit searching upward from pointer, wrapping CHANNELS-1 -> 0. req_ready[g]=1 for that cycle; the vector is latched into an internal buffer; pointer <= g+1 (mod CHANNELS); go SEND. A requester holding req_valid is served within CHANNELS grants.
- SEND: dt_sample = latched feature[cnt], dt_valid = dt_ready. cnt advances only on beats with dt_ready=1; when dt_ready=0, dt_valid=0 and cnt holds. After beat FEATURES-1, cnt <= 0 and go WAIT. Feature 0 is sent first.
- WAIT: dt_valid=0. On dt_out_valid=1 register level/path, res_channel <= g, go RESP. dt_out_valid outside WAIT is ignored.
- RESP: res_valid=1, fields stable until res_valid&res_ready; then IDLE. Minimum turnaround IDLE->IDLE = FEATURES+3 cycles plus dtree latency.
- Reset asserted mid-operation: immediate return to IDLE; the partial vector is discarded, no result is produced, and the pointer returns to 0.
- cfg_wr arriving during SEND/WAIT/RESP is stalled (cfg_ready=0) until IDLE.

Optional Feature:
DTREE_ARB_TIMEOUT_EN. Defined: a counter runs in WAIT; if dt_out_valid has not arrived after TIMEOUT_CYCLES cycles, go RESP with res_err=1, res_level=0, res_path=0. Undefined: no counter; WAIT is held indefinitely; res_err is tied to 0.

Test Plan:
- Reset then cfg_wr addr=3 data=0x2A5F00 -> cfg_ready one cycle, dt_wr_node pulse next cycle with addr 3/data 0x2A5F00, no dt_valid activity.
- Channel 2 only, features {100,200,300}, dt_ready=1, dtree returns level=2 path=2'b01 -> dt_sample 100,200,300 on consecutive beats; res_channel=2, level=2, path=01.
- All 4 channels valid continuously -> grants in order 0,1,2,3,0; each req_ready is a single-cycle pulse.
- dt_ready dropped for 2 cycles after the first beat -> dt_valid low for 2 cycles, feature 1 held, sequence completes with 3 beats total.
- res_ready held 0 for 5 cycles -> res_* stable, no new grant, req_ready=0 throughout; cfg_wr during RESP is accepted only after the handshake.
- With DTREE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no dt_out_valid -> res_valid with res_err=1 at 8 cycles after WAIT entry; reset asserted mid-SEND -> dt_valid=0 next edge, no result.
